// File: rtl/decoder_onehot_seq.sv
// decoder_onehot_seq: registered one-hot decoder with latch, pulse and scan modes.
// Ports: clk, rst (async, active high); in_valid/in_ready request handshake;
//   Input (low SEL_BITS bits = sel, the rest ignored); mode 00 latch, 01 pulse,
//   10 scan, 11 latch; dis synchronous abort; Output one-hot or zero;
//   out_valid high exactly when Output is non-zero.
module decoder_onehot_seq #(
   parameter int    UUID     = 0,
   parameter string NAME     = "",
   parameter int    IN_WIDTH = 8,
   parameter int    SEL_BITS = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_WIDTH-1:0]        Input,
   input  logic [1:0]                 mode,
   input  logic                       dis,
   output logic [(1<<SEL_BITS)-1:0]   Output,
   output logic                       out_valid
);
   localparam int OUT_COUNT = 1 << SEL_BITS;
   localparam int    unused_uuid = UUID;
   localparam string unused_name = NAME;
   typedef enum logic [1:0] {IDLE, HOLD, PULSE, SCAN} state_t;
   state_t               state_q, state_d;
   logic [OUT_COUNT-1:0] out_d, sel_oh;
   logic                 accept, unused_in;
   assign unused_in = ^Input;
   // busy is exactly the SCAN state
   assign in_ready = state_q != SCAN;
   assign accept   = in_valid && in_ready && !dis;
   assign sel_oh   = OUT_COUNT'(1) << Input[SEL_BITS-1:0];
   always_comb begin
      state_d = state_q;
      out_d   = Output;
      if (dis) begin
         state_d = IDLE;
         out_d   = '0;
      end else if (accept) begin
         out_d   = sel_oh;
         state_d = mode == 2'b01 ? PULSE : mode == 2'b10 ? SCAN : HOLD;
      end else if (state_q == PULSE || (state_q == SCAN && Output[OUT_COUNT-1])) begin
         state_d = IDLE;
         out_d   = '0;
      end else if (state_q == SCAN) begin
         out_d   = Output << 1;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         Output    <= '0;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         Output    <= out_d;
         out_valid <= |out_d;
      end
   end
endmodule

// File: tb/tb_decoder_onehot_seq.sv
// tb_decoder_onehot_seq: scoreboard bench with a queue-based output-sequence model
module tb_decoder_onehot_seq;
   logic clk = 0, rst = 1;
   logic in_valid = 0, dis = 0;
   logic [7:0] din = 0;
   logic [1:0] mode = 0;
   logic [7:0] dout;
   logic in_ready, out_valid;
   logic v1 = 0, i1 = 0, v6 = 0;
   logic [7:0] i6 = 0;
   logic [1:0] o1;
   logic [63:0] o6;
   logic r1, r6, ov1, ov6;
   int checks = 0, errors = 0;
   logic [8:0] exp_q[$];
   logic [7:0] held = 0, cur = 0;
   logic [7:0] rest[$];
   bit scanning = 0;

   always #5 clk = ~clk;

   decoder_onehot_seq dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .Input(din), .mode(mode), .dis(dis), .Output(dout), .out_valid(out_valid));
   decoder_onehot_seq #(.IN_WIDTH(1), .SEL_BITS(1)) u1 (.clk(clk), .rst(rst), .in_valid(v1),
      .in_ready(r1), .Input(i1), .mode(2'b10), .dis(1'b0), .Output(o1), .out_valid(ov1));
   decoder_onehot_seq #(.IN_WIDTH(8), .SEL_BITS(6)) u6 (.clk(clk), .rst(rst), .in_valid(v6),
      .in_ready(r6), .Input(i6), .mode(2'b10), .dis(1'b0), .Output(o6), .out_valid(ov6));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, req);
      end
   endtask

   // Reference: an accept queues the whole future output sequence for its mode;
   // each later edge consumes one entry, falling back to the held latch value.
   task automatic step(input bit v, input logic [7:0] in, input int m, input bit d);
      bit busy_now;
      int s;
      @(negedge clk);
      in_valid = v; din = in; mode = 2'(m); dis = d;
      busy_now = scanning && cur != 0;
      s = int'(in[2:0]);
      if (d) begin
         rest.delete(); held = 0; scanning = 0; cur = 0;
      end else if (v && !busy_now) begin
         rest.delete();
         cur = 8'd1 << s;
         scanning = (m == 2);
         held = (m == 0 || m == 3) ? cur : 8'd0;
         if (m == 2) for (int k = s + 1; k < 8; k++) rest.push_back(8'd1 << k);
      end else begin
         cur = rest.size() != 0 ? rest.pop_front() : held;
      end
      exp_q.push_back({!(scanning && cur != 0), cur});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 8'($urandom), int'($urandom_range(0, 3)), 0);
   endtask

   task automatic sweep(input bit w, input int s);
      int n, oc;
      logic [63:0] sw_out;
      oc = w ? 64 : 2;
      @(negedge clk);
      if (w) begin i6 = {2'($urandom), 6'(s)}; v6 = 1; end
      else begin i1 = 1'(s); v1 = 1; end
      @(negedge clk);
      v1 = 0; v6 = 0;
      n = 0;
      sw_out = w ? o6 : {62'd0, o1};
      while ((w ? ov6 : ov1) && n < 70) begin
         chk("sweep_onehot", sw_out, 64'd1 << (s + n));
         n++;
         @(negedge clk);
         sw_out = w ? o6 : {62'd0, o1};
      end
      chk("sweep_len", 64'(n), 64'(oc - s));
      chk("sweep_zero", sw_out, 64'd0);
   endtask

   initial begin : monitor
      logic [8:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out", 64'(dout), 64'(e[7:0]));
            chk("out_valid", 64'(out_valid), 64'(e[7:0] != 0));
            chk("in_ready", 64'(in_ready), 64'(e[8]));
         end
      end
   end

   initial begin
      #1;
      chk("rst_out", 64'(dout), 0);
      chk("rst_valid", 64'(out_valid), 0);
      chk("rst_ready", 64'(in_ready), 1);
      @(negedge clk);
      rst = 0;
      step(1, 8'hF3, 0, 0);
      idle(10);
      chk("latch_hold", 64'(dout), 64'h08);
      chk("latch_valid", 64'(out_valid), 1);
      step(1, 8'hF8, 1, 0);
      step(1, 8'hFF, 1, 0);
      idle(3);
      step(1, 8'h05, 2, 0);
      step(1, 8'h01, 0, 0);
      idle(4);
      chk("scan_done", 64'(dout), 0);
      step(1, 8'h00, 2, 0);
      step(0, 8'h00, 2, 0);
      step(0, 8'h00, 2, 1);
      step(1, 8'h03, 0, 1);
      step(0, 8'h00, 0, 0);
      chk("abort_out", 64'(dout), 0);
      chk("abort_ready", 64'(in_ready), 1);
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 3)),
              $urandom_range(0, 15) == 0);
      step(0, 8'h00, 0, 1);
      step(1, 8'h01, 2, 0);
      step(0, 8'h00, 0, 0);
      @(posedge clk);
      #3;
      rst = 1;
      #1;
      chk("async_out", 64'(dout), 0);
      chk("async_ready", 64'(in_ready), 1);
      rest.delete(); held = 0; cur = 0; scanning = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      step(1, 8'hFA, 0, 0);
      idle(3);
      chk("post_rst_latch", 64'(dout), 64'h04);
      @(posedge clk);
      #2;
      chk("sb_drain", 64'(exp_q.size()), 0);
      sweep(0, 0);
      sweep(0, 1);
      sweep(1, 0);
      sweep(1, 37);
      sweep(1, 63);
      sweep(1, int'($urandom_range(0, 63)));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
